// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and helpers for the memory-access stage
package mem_stage_pkg;

    // funct3 access size/sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // access size, funct3[1:0]
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    // writeback result source select
    localparam logic [1:0] RS_ALU  = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC4  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Halfwords need an even address, words a 4-byte aligned one; size code 11 is treated as word.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic w_mis;
        case (funct3[1:0])
            SZ_B:    w_mis = 1'b0;
            SZ_H:    w_mis = addr_lo[0];
            default: w_mis = (addr_lo != 2'b00);
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// rtl/mem_stage_lsu_align.sv - store lane replication/byte enables and load lane extract/extend
module mem_stage_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be_store,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store: replicate the datum across every lane it could occupy and enable only the addressed bytes
    always_comb begin
        o_wdata    = i_store_data;
        o_be_store = 4'b1111;
        case (i_funct3[1:0])
            SZ_B: begin
                o_wdata    = {4{i_store_data[7:0]}};
                o_be_store = 4'b0001 << i_addr_lo;
            end
            SZ_H: begin
                o_wdata    = {2{i_store_data[15:0]}};
                o_be_store = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                o_wdata    = i_store_data;
                o_be_store = 4'b1111;
            end
        endcase
    end

    // Load: select the addressed lane, then sign- or zero-extend by funct3
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_HU:   o_load_data = {16'd0, w_half};
            F3_W:    o_load_data = i_rdata;
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: bus handshake FSM, stall generation, writeback registers
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DR,
    input  logic [4:0]  DR_num,
    input  logic [31:0] WriteData,
    input  logic [31:0] PC_plus_4,
    input  logic [1:0]  ResultSrc,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        RegWrite,
    input  logic [2:0]  ALUControl,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] ALUResData,
    output logic [31:0] DataReadData,
    output logic [31:0] WB_PC_plus_4,
    output logic [4:0]  WB_DR_num,
    output logic        WB_RegWrite,
    output logic [1:0]  WB_ResultSrc,
    output logic        misalign,
    output logic        bus_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_wait_cnt;
    logic [CW-1:0]  w_cnt_nxt;

    logic           w_mem_op;
    logic           w_misalign;
    logic           w_mem_go;
    logic           w_timeout;
    logic           w_is_load;
    logic [31:0]    w_wdata;
    logic [3:0]     w_be_store;
    logic [31:0]    w_load_data;

    assign w_mem_op   = MemRead | MemWrite;
    assign w_misalign = w_mem_op & is_misaligned(ALUControl, DR[1:0]);
    assign w_mem_go   = w_mem_op & ~w_misalign;
    assign w_is_load  = MemRead & ~MemWrite;
    assign w_timeout  = (r_state == WAIT) & (r_wait_cnt == CW'(MAX_WAIT)) & ~dmem_ready;

    // Request and stall are gated by reset so an in-flight access drops in the very cycle reset asserts.
    assign dmem_req   = reset & w_mem_go;
    assign mem_stall  = reset & w_mem_go & ~dmem_ready & ~w_timeout;
    assign dmem_we    = MemWrite;
    assign dmem_addr  = {DR[31:2], 2'b00};
    assign dmem_wdata = w_wdata;
    assign dmem_be    = MemWrite ? w_be_store : 4'b1111;

    mem_stage_lsu_align u_lsu_align (
        .i_funct3     (ALUControl),
        .i_addr_lo    (DR[1:0]),
        .i_store_data (WriteData),
        .i_rdata      (dmem_rdata),
        .o_wdata      (w_wdata),
        .o_be_store   (w_be_store),
        .o_load_data  (w_load_data)
    );

    // Next state: enter WAIT when the bus does not answer at once, leave on ready or timeout
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (w_mem_go && !dmem_ready) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            WAIT: begin
                if (dmem_ready || w_timeout || !w_mem_go) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_wait_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
        end
    end

    // Writeback registers: capture on non-stalled cycles, insert a bubble while stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            ALUResData   <= '0;
            DataReadData <= '0;
            WB_PC_plus_4 <= '0;
            WB_DR_num    <= '0;
            WB_RegWrite  <= 1'b0;
            WB_ResultSrc <= '0;
            misalign     <= 1'b0;
            bus_err      <= 1'b0;
        end else if (mem_stall) begin
            WB_RegWrite  <= 1'b0;
            misalign     <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            ALUResData   <= DR;
            DataReadData <= (w_is_load && w_mem_go && dmem_ready) ? w_load_data : 32'd0;
            WB_PC_plus_4 <= PC_plus_4;
            WB_DR_num    <= DR_num;
            WB_RegWrite  <= RegWrite & ~w_misalign & ~w_timeout;
            WB_ResultSrc <= ResultSrc;
            misalign     <= w_misalign;
            bus_err      <= w_timeout;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized scoreboard bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int MAX_WAIT = 16;
    localparam int NEVER    = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] DR, WriteData, PC_plus_4, dmem_rdata;
    logic [4:0]  DR_num;
    logic [1:0]  ResultSrc;
    logic        MemWrite, MemRead, RegWrite, dmem_ready;
    logic [2:0]  ALUControl;
    logic        dmem_req, dmem_we, mem_stall, WB_RegWrite, misalign, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, ALUResData, DataReadData, WB_PC_plus_4;
    logic [3:0]  dmem_be;
    logic [4:0]  WB_DR_num;
    logic [1:0]  WB_ResultSrc;

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .DR(DR), .DR_num(DR_num), .WriteData(WriteData),
        .PC_plus_4(PC_plus_4), .ResultSrc(ResultSrc), .MemWrite(MemWrite), .MemRead(MemRead),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .ALUResData(ALUResData),
        .DataReadData(DataReadData), .WB_PC_plus_4(WB_PC_plus_4), .WB_DR_num(WB_DR_num),
        .WB_RegWrite(WB_RegWrite), .WB_ResultSrc(WB_ResultSrc), .misalign(misalign), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] alu, rdd, pc4, addr, wdata;
        logic [3:0]  be;
        logic [4:0]  drn;
        logic [1:0]  rs;
        logic        rw, mis, err, req, we;
        int          stalls;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 0;
    bit   pend_prev, prev_stall;
    int   stall_cnt;
    logic [2:0] ld_f3[5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    logic [2:0] st_f3[3] = '{F3_B, F3_H, F3_W};
    logic [1:0] rs_tab[3] = '{RS_ALU, RS_LOAD, RS_PC4};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected writeback, bus fields and stall count from the access rules
    function automatic exp_t model(input logic [31:0] dr, input logic [4:0] drn, input logic [31:0] wd,
                                   input logic [31:0] pc4, input logic [1:0] rs, input logic mw,
                                   input logic mr, input logic rw, input logic [2:0] f3,
                                   input int lat, input logic [31:0] rword);
        exp_t e;
        logic [1:0]  lo;
        logic [31:0] bv, hv, val;
        bit mem, go, tout;
        lo   = dr[1:0];
        mem  = mr || mw;
        e.mis = mem && ((f3[1:0] == 2'd1 && lo[0]) || (f3[1:0] >= 2'd2 && lo != 2'd0));
        go   = mem && !e.mis;
        tout = go && (lat > MAX_WAIT);
        e.stalls = !go ? 0 : (tout ? MAX_WAIT : lat);
        bv = (rword >> (8 * lo)) & 32'hFF;
        hv = (rword >> (16 * lo[1])) & 32'hFFFF;
        if (f3[1:0] == 2'd0)      val = (!f3[2] && bv >= 128)   ? bv - 32'd256   : bv;
        else if (f3[1:0] == 2'd1) val = (!f3[2] && hv >= 32768) ? hv - 32'd65536 : hv;
        else                      val = rword;
        e.rdd  = (go && !tout && mr && !mw) ? val : 32'd0;
        e.alu  = dr;
        e.pc4  = pc4;
        e.drn  = drn;
        e.rs   = rs;
        e.rw   = rw && !e.mis && !tout;
        e.err  = tout;
        e.req  = go;
        e.we   = mw;
        e.addr = dr & 32'hFFFF_FFFC;
        if (!mw)                  e.be = 4'hF;
        else if (f3[1:0] == 2'd0) e.be = 4'(1 << lo);
        else if (f3[1:0] == 2'd1) e.be = lo[1] ? 4'hC : 4'h3;
        else                      e.be = 4'hF;
        if (f3[1:0] == 2'd0)      e.wdata = (wd & 32'hFF) * 32'h0101_0101;
        else if (f3[1:0] == 2'd1) e.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        else                      e.wdata = wd;
        return e;
    endfunction

    // Present one instruction, hold it through its expected stall, act as the bus responder
    task automatic issue(input logic [31:0] dr, input logic [4:0] drn, input logic [31:0] wd,
                         input logic [31:0] pc4, input logic [1:0] rs, input logic mw, input logic mr,
                         input logic rw, input logic [2:0] f3, input int lat, input logic [31:0] rword);
        exp_t e;
        e = model(dr, drn, wd, pc4, rs, mw, mr, rw, f3, lat, rword);
        q.push_back(e);
        DR = dr; DR_num = drn; WriteData = wd; PC_plus_4 = pc4; ResultSrc = rs;
        MemWrite = mw; MemRead = mr; RegWrite = rw; ALUControl = f3;
        for (int k = 0; k <= e.stalls; k++) begin
            if (e.req) begin
                dmem_ready = (k == lat);
                dmem_rdata = (k == lat) ? rword : $urandom;
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pop a record whenever the stage completes, check bubbles and bus fields every cycle
    always @(negedge clk) begin
        if (!mon_en) begin
            pend_prev  = 0;
            prev_stall = 0;
            stall_cnt  = 0;
        end else begin
            if (pend_prev) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_underflow actual=empty expected=record at %0t", $time);
                end else begin
                    mon_e = q.pop_front();
                    chk("ALUResData", ALUResData, mon_e.alu);
                    chk("DataReadData", DataReadData, mon_e.rdd);
                    chk("WB_PC_plus_4", WB_PC_plus_4, mon_e.pc4);
                    chk("WB_DR_num", 32'(WB_DR_num), 32'(mon_e.drn));
                    chk("WB_RegWrite", 32'(WB_RegWrite), 32'(mon_e.rw));
                    chk("WB_ResultSrc", 32'(WB_ResultSrc), 32'(mon_e.rs));
                    chk("misalign", 32'(misalign), 32'(mon_e.mis));
                    chk("bus_err", 32'(bus_err), 32'(mon_e.err));
                    chk("stall_cycles", 32'(stall_cnt), 32'(mon_e.stalls));
                    stall_cnt = 0;
                end
            end else if (prev_stall) begin
                chk("bubble_regwrite", 32'(WB_RegWrite), 32'd0);
                chk("bubble_pulses", 32'({misalign, bus_err}), 32'd0);
            end
            if (q.size() > 0) begin
                mon_e = q[0];
                chk("dmem_req", 32'(dmem_req), 32'(mon_e.req));
                if (mon_e.req) begin
                    chk("dmem_we", 32'(dmem_we), 32'(mon_e.we));
                    chk("dmem_addr", dmem_addr, mon_e.addr);
                    chk("dmem_be", 32'(dmem_be), 32'(mon_e.be));
                    if (mon_e.we) chk("dmem_wdata", dmem_wdata, mon_e.wdata);
                end
                if (mem_stall) stall_cnt++;
            end
            pend_prev  = (q.size() > 0) && !mem_stall;
            prev_stall = mem_stall;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] dr, wd, rw32;
        logic [2:0]  f3;
        logic        mw, mr, rw;
        logic [1:0]  rs;
        int          op, lat, r;

        reset = 1'b0; DR = 32'h0; DR_num = 5'd0; WriteData = 32'h0; PC_plus_4 = 32'h0;
        ResultSrc = 2'd0; MemWrite = 1'b0; MemRead = 1'b1; RegWrite = 1'b1; ALUControl = F3_W;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_mem_stall", 32'(mem_stall), 32'd0);
        chk("rst_wb", {ALUResData | DataReadData | WB_PC_plus_4}, 32'd0);
        chk("rst_ctl", 32'({WB_DR_num, WB_RegWrite, WB_ResultSrc, misalign, bus_err}), 32'd0);
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1;

        issue(32'h1234, 5'd3, 32'h0, 32'h40, RS_ALU, 0, 0, 1, 3'b000, 0, 32'h0);
        issue(32'h103, 5'd5, 32'h0, 32'h44, RS_LOAD, 0, 1, 1, F3_B, 0, 32'h80FF_0000);
        issue(32'h202, 5'd0, 32'hABCD, 32'h48, RS_ALU, 1, 0, 0, F3_H, 3, 32'h0);
        issue(32'h101, 5'd7, 32'h0, 32'h4C, RS_LOAD, 0, 1, 1, F3_W, 0, 32'h0);
        issue(32'h102, 5'd8, 32'h0, 32'h50, RS_LOAD, 0, 1, 1, F3_HU, 0, 32'h8001_0000);
        issue(32'h300, 5'd9, 32'h0, 32'h54, RS_LOAD, 0, 1, 1, F3_W, NEVER, 32'h0);
        issue(32'h304, 5'd10, 32'h0, 32'h58, RS_LOAD, 0, 1, 1, F3_W, MAX_WAIT, 32'hCAFE_F00D);

        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 3);
            dr = $urandom; wd = $urandom; rw32 = $urandom;
            mw = 0; mr = 0; rw = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            rs = rs_tab[$urandom_range(0, 2)];
            case (op)
                1: begin mr = 1; f3 = ld_f3[$urandom_range(0, 4)]; rs = RS_LOAD; end
                2: begin mw = 1; mr = ($urandom_range(0, 7) == 0); f3 = st_f3[$urandom_range(0, 2)]; end
                3: begin rs = RS_PC4; rw = 1; end
                default: ;
            endcase
            if ((mr || mw) && $urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) dr[0] = 1'b0;
                else if (f3[1:0] == 2'd2) dr[1:0] = 2'd0;
            end
            r = $urandom_range(0, 19);
            if (r < 12)      lat = r % 4;
            else if (r < 15) lat = MAX_WAIT;
            else if (r < 17) lat = MAX_WAIT - 1;
            else             lat = NEVER;
            issue(dr, 5'($urandom), wd, $urandom, rs, mw, mr, rw, f3, lat, rw32);
        end

        @(negedge clk); #1;
        mon_en = 0;
        chk("sb_drained", 32'(q.size()), 32'd0);

        // Drop reset in the middle of a WAIT
        @(posedge clk); #1;
        DR = 32'h400; DR_num = 5'd12; PC_plus_4 = 32'h77; MemRead = 1'b1; MemWrite = 1'b0;
        RegWrite = 1'b1; ALUControl = F3_W; ResultSrc = RS_LOAD; dmem_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("wait_stall", 32'(mem_stall), 32'd1);
        reset = 1'b0;
        #2;
        chk("rstwait_req", 32'(dmem_req), 32'd0);
        chk("rstwait_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("rstwait_wb", {ALUResData | DataReadData | WB_PC_plus_4}, 32'd0);
        chk("rstwait_ctl", 32'({WB_DR_num, WB_RegWrite, WB_ResultSrc, misalign, bus_err}), 32'd0);
        reset  = 1'b1;
        mon_en = 1;
        issue(32'h408, 5'd13, 32'h0, 32'h80, RS_LOAD, 0, 1, 1, F3_W, NEVER, 32'h0);
        issue(32'h40C, 5'd14, 32'h0, 32'h84, RS_LOAD, 0, 1, 1, F3_H, 0, 32'h1234_8765);
        @(negedge clk); #1;
        chk("sb_drained_end", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
